// File: rtl/pattern_scan_engine.sv
// Memory-port scanner: reads a 4-bit pattern, scans a byte window, and counts
// bytes containing that nibble at any bit offset, then writes the count back.
module pattern_scan_engine #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int PAT_ADDR   = 6,
  parameter int CNT_ADDR   = 7,
  parameter int START_ADDR = 32,
  parameter int END_ADDR   = 95
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic          busy,
  output logic          done,
  output logic [7:0]    count
);

  localparam int N = END_ADDR - START_ADDR + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PAT   = 3'd1;
  localparam logic [2:0] S_PATW  = 3'd2;
  localparam logic [2:0] S_SCAN  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [AW:0] END_EXT  = (AW+1)'(END_ADDR);
  localparam logic [AW:0] LAST_IDX = (AW+1)'(N - 1);

  // A byte counts once if the nibble appears at any of the DW-3 bit offsets.
  function automatic logic nibble_hit(input logic [DW-1:0] b, input logic [3:0] p);
    logic h;
    h = 1'b0;
    for (int i = 0; i <= DW - 4; i++) begin
      if (b[i +: 4] == p) begin
        h = 1'b1;
      end else begin
        h = h;
      end
    end
    return h;
  endfunction

  logic [2:0]  state;
  logic [3:0]  pattern;
  logic [AW:0] idx;
  logic        hit;
  logic [AW:0] addr_next;
  logic [7:0]  count_next;

  // Match evaluation and next sequential address for the scan pipeline.
  always_comb begin
    hit        = nibble_hit(mem_rdata, pattern);
    addr_next  = {1'b0, mem_addr} + (AW+1)'(1);
    count_next = count + {7'd0, hit};
  end

  // Control FSM; every memory-port output is registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= 8'd0;
      pattern   <= 4'd0;
      idx       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          mem_we <= 1'b0;
          if (start) begin
            state    <= S_PAT;
            count    <= 8'd0;
            done     <= 1'b0;
            busy     <= 1'b1;
            mem_addr <= AW'(PAT_ADDR);
            mem_re   <= 1'b1;
          end else begin
            mem_re <= 1'b0;
          end
        end
        S_PAT: begin
          state    <= S_PATW;
          mem_addr <= AW'(START_ADDR);
          mem_re   <= 1'b1;
        end
        S_PATW: begin
          // Only the low nibble of the pattern byte is meaningful.
          pattern  <= mem_rdata[3:0];
          idx      <= '0;
          state    <= S_SCAN;
          mem_addr <= addr_next[AW-1:0];
          mem_re   <= (addr_next <= END_EXT);
        end
        S_SCAN: begin
          count <= count_next;
          if (idx == LAST_IDX) begin
            state     <= S_WRITE;
            mem_re    <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= AW'(CNT_ADDR);
            mem_wdata <= DW'(count_next);
          end else begin
            idx      <= idx + (AW+1)'(1);
            mem_addr <= addr_next[AW-1:0];
            mem_re   <= (addr_next <= END_EXT);
          end
        end
        S_WRITE: begin
          state    <= S_DONE;
          mem_we   <= 1'b0;
          mem_re   <= 1'b0;
          mem_addr <= '0;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
        default: begin
          state  <= S_IDLE;
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_engine.sv
// Bench for pattern_scan_engine: byte-wide memory model, directed and random
// scans compared against a nibble-search reference.
module tb_pattern_scan_engine;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] mem_addr;
  logic       mem_re;
  logic [7:0] mem_rdata;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       done;
  logic [7:0] count;

  logic [7:0] mem [0:255];
  logic [7:0] init_mem [0:255];
  logic       load_req = 1'b0;
  int         writes = 0;
  int         bad_access = 0;
  logic [7:0] last_waddr = 8'd0;
  logic [7:0] last_wdata = 8'd0;
  int         checks = 0;
  int         errors = 0;

  pattern_scan_engine dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  // Synchronous memory with a bulk-load port and access policing.
  always @(posedge clk) begin
    if (load_req) begin
      for (int a = 0; a < 256; a++) mem[a] = init_mem[a];
    end
    if (mem_re === 1'b1) begin
      mem_rdata <= mem[mem_addr];
      if (!(mem_addr == 8'd6 || (mem_addr >= 8'd32 && mem_addr <= 8'd95))) bad_access++;
    end
    if (mem_we === 1'b1) begin
      mem[mem_addr] = mem_wdata;
      writes++;
      last_waddr = mem_addr;
      last_wdata = mem_wdata;
      if (mem_addr != 8'd7) bad_access++;
    end
    if (mem_re === 1'b1 && mem_we === 1'b1) bad_access++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: shift the byte right by 0..4 and compare the low nibble.
  function automatic int model_count();
    int c = 0;
    logic [7:0] pb = init_mem[6];
    for (int a = 32; a <= 95; a++) begin
      bit found = 0;
      for (int s = 0; s <= 4; s++)
        if (((init_mem[a] >> s) & 8'h0F) == (pb & 8'h0F)) found = 1;
      if (found) c++;
    end
    return c;
  endfunction

  task automatic clear_init();
    for (int a = 0; a < 256; a++) init_mem[a] = 8'h00;
  endtask

  task automatic load();
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  task automatic do_run(input string tag, input int exp, input bit repulse);
    int w0 = writes;
    int b0 = bad_access;
    int busy_err = 0;
    int done_cyc = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "_c1_done"}, done, 0);
    chk({tag, "_c1_busy"}, busy, 1);
    for (int cyc = 1; cyc <= 150; cyc++) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (!busy) busy_err++;
      start = (repulse && cyc == 10);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, done_cyc, 68);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_busy_run"}, busy_err, 0);
    chk({tag, "_count"}, count, exp);
    chk({tag, "_nwrites"}, writes - w0, 1);
    chk({tag, "_waddr"}, last_waddr, 7);
    chk({tag, "_wdata"}, last_wdata, exp);
    chk({tag, "_mem7"}, mem[7], exp);
    chk({tag, "_illegal"}, bad_access - b0, 0);
  endtask

  initial begin
    int w0;
    repeat (3) @(negedge clk);
    chk("rst_addr", mem_addr, 0);
    chk("rst_re", mem_re, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    reset_n = 1'b1;

    clear_init(); load();
    do_run("zeros", 64, 1'b0);

    clear_init();
    init_mem[6] = 8'h0F; init_mem[32] = 8'hF0; init_mem[50] = 8'h1E;
    init_mem[95] = 8'h0F; init_mem[40] = 8'hFF;
    load();
    do_run("dir4", 4, 1'b0);

    clear_init();
    init_mem[6] = 8'h0F; init_mem[31] = 8'hFF; init_mem[96] = 8'hFF;
    load();
    do_run("bound", 0, 1'b0);

    clear_init();
    init_mem[6] = 8'hA5; init_mem[33] = 8'h0A; init_mem[34] = 8'h50;
    load();
    do_run("hipat", 2, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 256; a++) init_mem[a] = 8'($urandom);
      load();
      do_run($sformatf("rand%0d", r), model_count(), 1'b0);
    end

    // Reset in the middle of a scan must abandon the write-back.
    clear_init();
    init_mem[6] = 8'h0F; init_mem[40] = 8'hFF; init_mem[7] = 8'h77;
    load();
    w0 = writes;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (29) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_re", mem_re, 0);
    chk("mid_we", mem_we, 0);
    chk("mid_addr", mem_addr, 0);
    chk("mid_count", count, 0);
    repeat (80) @(negedge clk);
    chk("mid_nwrites", writes - w0, 0);
    chk("mid_mem7", mem[7], 8'h77);
    chk("mid_done_late", done, 0);

    clear_init();
    init_mem[6] = 8'h0F; init_mem[32] = 8'hF0; init_mem[50] = 8'h1E;
    init_mem[95] = 8'h0F; init_mem[40] = 8'hFF;
    load();
    do_run("repulse", 4, 1'b1);
    do_run("restart", 4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_scan_engine.md
Name: pattern_scan_engine

Overview:
- Hardware scanner for the "program 2" workload: counts data-memory bytes that contain a 4-bit pattern.
- Runs through the shared data-memory port. It reads the pattern byte, then reads every byte in the scan window, then writes the match count back to memory.
- Serves as a hardware reference and accelerator that the CPU/bench side hands control to. It is the reading/responding end of the same memory convention: pattern at address 6, result at address 7, data at 32..95.

Parameters:
- AW, 8, data-memory address width
- DW, 8, data-memory data width
- PAT_ADDR, 6, address of the pattern byte (only bits [3:0] are used)
- CNT_ADDR, 7, address the match count is written to
- START_ADDR, 32, first scanned address
- END_ADDR, 95, last scanned address (inclusive); N = END_ADDR-START_ADDR+1 = 64

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- start  input  1  one-cycle (or level) request, sampled only in IDLE or DONE
- mem_addr  output  AW  memory address
- mem_re  output  1  read enable; memory registers the address, and mem_rdata is valid the following cycle
- mem_rdata  input  DW  read data
- mem_we  output  1  write enable (one cycle)
- mem_wdata  output  DW  write data
- busy  output  1  high from PAT through WRITE
- done  output  1  high in DONE
- count  output  8  running/final match count

Behaviour:
- Reset (reset_n=0 at clk edge) forces the following, regardless of state:
  - state=IDLE
  - mem_addr=0, mem_re=0, mem_we=0, mem_wdata=0
  - busy=0, done=0, count=0
  - pattern register=0
- States: IDLE, PAT, PATW, SCAN, WRITE, DONE. Cycle C0 is the cycle in which start=1 is sampled.
- IDLE/DONE -> PAT on start=1. Entering PAT clears count and, if coming from DONE, clears done.
- C1 (PAT): mem_addr=PAT_ADDR, mem_re=1.
- C2 (PATW):
  - mem_rdata=mem[PAT_ADDR]; latch pattern=mem_rdata[3:0], ignoring bits [7:4].
  - Concurrently drive mem_addr=START_ADDR, mem_re=1.
- C3..C(N+2) (SCAN): in cycle C3+k, mem_rdata=mem[START_ADDR+k].
  - Evaluate the match against the latched pattern.
  - Drive mem_addr=START_ADDR+k+1, with mem_re=1 only while that address is ≤ END_ADDR.
  - After the byte for END_ADDR is consumed, go to WRITE.
- Match rule: the byte matches if any window rdata[i+3:i] for i=0..4 equals the pattern.
  - Each byte counts at most once (e.g. 0xFF with pattern 0xF counts 1).
  - count increments by 1 per matching byte. Maximum is N=64, so no overflow for 8 bits.
- C(N+3) (WRITE): mem_we=1, mem_addr=CNT_ADDR, mem_wdata=count, mem_re=0. Exactly one write per run.
- C(N+4) (DONE): done=1, busy=0, count holds its final value. Default N=64 gives done first high in C68.
  - done stays high until reset or a new start.
- start while busy (PAT..WRITE) is ignored and has no effect on the run.
- Addresses outside [START_ADDR, END_ADDR] other than PAT_ADDR/CNT_ADDR are never read or written.
- Reset mid-run: the write is abandoned, so memory is not modified. The block returns to IDLE next cycle with all outputs at reset values.
- mem_we and mem_re are never asserted in the same cycle.

Test Plan:
- Memory all 0x00, mem[6]=0x00, start pulse → done rises in C68, mem[7]=64, count=64, exactly one write to address 7.
- mem[6]=0x0F; mem[32]=0xF0, mem[50]=0x1E, mem[95]=0x0F, mem[40]=0xFF, all other bytes 0x00 → mem[7]=4 (0xFF counted once).
- Boundary: mem[31]=0xFF, mem[96]=0xFF, mem[6]=0x0F, window all 0x00 → mem[7]=0; verify no read issued at 31 or 96.
- mem[6]=0xA5 (pattern 0x5), mem[33]=0x0A, mem[34]=0x50, rest 0x00 → mem[7]=2; upper pattern bits are ignored.
- reset_n low for one cycle at C30 with mem[7] preset to 0x77 → no write occurs, mem[7] stays 0x77, done=0, busy=0 from the next cycle.
- start re-pulsed at C10 → ignored, done still rises at C68. A start in DONE → done drops next cycle, and the identical memory gives the identical count at C68 of the new run.
